axis_measure_pulse_mc: RTL and testbench
========================================

AXIS_MEASURE_PULSE_MC -- requirements
Module: axis_measure_pulse_mc

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 16: sample width per channel.
REQ-002 SHALL have parameter NUM_CH, default 2: channel count, 1..4.
REQ-003 SHALL have parameter CNTR_WIDTH, default 16: phase-length counter width.
REQ-004 SHALL have parameter BRAM_ADDR_WIDTH, default 10; BRAM_DATA_WIDTH, default 16.
REQ-005 SHALL have ports, one clock, synchronous active-high reset:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- cfg_data  in  2*CNTR_WIDTH+2*BRAM_ADDR_WIDTH+33  {clr, pulse_length, waveform_length, threshold[31:0] signed, width, ramp}, LSB first = ramp
- s_axis_tdata  in  NUM_CH*AXIS_TDATA_WIDTH  packed signed samples, ch0 in LSBs
- s_axis_tvalid  in  1; s_axis_tready  out  1
- m_axis_tdata  out  BRAM_DATA_WIDTH; m_axis_tvalid, m_axis_tlast  out  1; m_axis_tready  in  1
- bram_porta_clk, bram_porta_rst  out  1; bram_porta_addr  out  BRAM_ADDR_WIDTH; bram_porta_rddata  in  BRAM_DATA_WIDTH
- overload  out  NUM_CH  per-channel result < threshold
- result_valid  out  1  one-cycle strobe, new results available
- case_id  out  3  current phase
- sts_data  out  32*NUM_CH  per-channel signed result

Function
REQ-006 s_axis_tready SHALL be constant 1; a sample is accepted on every cycle with s_axis_tvalid=1.
REQ-007 Phase FSM: PRE(0) -> RAMP_UP(1) -> PULSE(2) -> RAMP_DOWN(3) -> POST(4) -> PRE; case_id = phase code.
REQ-008 Sample counts per phase: PRE and POST width>>1, RAMP_UP and RAMP_DOWN ramp, PULSE width; the transition SHALL occur on the last accepted sample of the phase with no dropped sample.
REQ-009 A zero-length phase SHALL be left after exactly one cycle; a sample accepted in that cycle is discarded.
REQ-010 ramp, width, threshold, pulse_length, waveform_length SHALL be latched on entry to PRE (and at reset) and held for the whole cycle.
REQ-011 Per channel: 32-bit signed offset accumulator (PRE+POST samples, sign-extended) and pulse accumulator (PULSE samples); wrap-around on overflow.
REQ-012 On the last POST sample: result[ch] = pulse_acc - offset_acc (32-bit), accumulators cleared, result_valid=1 in the following cycle.
REQ-013 overload[ch] SHALL be registered, updated together with result.
REQ-014 Playback: segment is [wfrm_start, wfrm_start+pulse_length]; addresses issued in order while m_axis_tready=1, wrapping to wfrm_start after the last one; 1-cycle BRAM read latency; m_axis_tdata = bram_porta_rddata.
REQ-015 m_axis_tvalid SHALL be 1 from the second cycle after reset release; m_axis_tlast SHALL accompany the last word of the segment.
REQ-016 On result update: if any overload bit is set and wfrm_start < waveform_length, wfrm_start += pulse_length+1 (modulo 2^BRAM_ADDR_WIDTH); otherwise wfrm_start=0. The new segment starts after the current word; a partially played segment is abandoned.
REQ-017 m_axis_tready=0 SHALL hold address and data, with no effect on measurement.
REQ-018 bram_porta_clk = aclk; bram_porta_rst = areset.

Reset
REQ-019 areset SHALL clear FSM to PRE, counters, accumulators, results, wfrm_start, playback pointer, and sticky flags.
REQ-020 Outputs in reset: overload=0, result_valid=0, sts_data=0, case_id=0, m_axis_tvalid=0, m_axis_tlast=0, bram_porta_addr=0.
REQ-021 Reset asserted mid-cycle SHALL discard partial sums, with no result_valid.

Configuration
REQ-022 With macro AXIS_MEASURE_PULSE_STICKY_EN defined, each overload bit SHALL be sticky until a cycle with cfg clr=1 (clr has priority over a simultaneous set). Without it, overload follows the latest result and clr is ignored.

Structure
REQ-023 Package axis_measure_pulse_pkg SHALL hold the phase enum, cfg field offsets and the ACC_WIDTH=32 constant.
REQ-024 Sub-module axis_measure_pulse_acc (one per channel, generate loop) SHALL hold the offset/pulse accumulators and the result subtract.

Verification
REQ-025 NUM_CH=2, ramp=2, width=4, ch0 PRE/POST=10, PULSE=50 -> result[0]=160 (200-40), result_valid after 2+2+4+2+2 samples plus 1 cycle.
REQ-026 threshold=200, result=160 -> overload[0]=1; wfrm_start 0 -> pulse_length+1 (pulse_length=7 -> 8).
REQ-027 waveform_length=8, wfrm_start=8, overload -> wfrm_start=0.
REQ-028 ramp=0 -> RAMP phases each last exactly 1 cycle, sample discarded; result unchanged otherwise.
REQ-029 m_axis_tready toggling 50% -> address sequence 0..7,0.. unbroken, tlast on addr 7 data only.
REQ-030 STICKY_EN: overload then non-overload result -> bit stays 1; clr=1 -> 0 next cycle.

Source files
------------

// File: rtl/axis_measure_pulse_pkg.sv
// -----------------------------------------------------------------------------
// axis_measure_pulse_pkg
// Shared definitions for the multi-channel pulse measurement block:
//   - phase_t          : measurement phase encoding (also driven on case_id)
//   - ACC_WIDTH        : width of the per-channel signed accumulators/results
//   - THR_WIDTH        : width of the signed overload threshold
//   - cfg_off_*()      : bit offsets of the fields packed into cfg_data,
//                        LSB first: ramp, width, threshold, waveform_length,
//                        pulse_length, clr
// -----------------------------------------------------------------------------
package axis_measure_pulse_pkg;

    localparam int ACC_WIDTH = 32;
    localparam int THR_WIDTH = 32;

    typedef enum logic [2:0] {
        PH_PRE       = 3'd0,
        PH_RAMP_UP   = 3'd1,
        PH_PULSE     = 3'd2,
        PH_RAMP_DOWN = 3'd3,
        PH_POST      = 3'd4
    } phase_t;

    localparam int CFG_OFF_RAMP = 0;

    function automatic int cfg_off_width(input int cw);
        return cw;
    endfunction

    function automatic int cfg_off_thr(input int cw);
        return 2 * cw;
    endfunction

    function automatic int cfg_off_wlen(input int cw);
        return 2 * cw + THR_WIDTH;
    endfunction

    function automatic int cfg_off_plen(input int cw, input int aw);
        return 2 * cw + THR_WIDTH + aw;
    endfunction

    function automatic int cfg_off_clr(input int cw, input int aw);
        return 2 * cw + THR_WIDTH + 2 * aw;
    endfunction

endpackage

// File: rtl/axis_measure_pulse_acc.sv
// -----------------------------------------------------------------------------
// axis_measure_pulse_acc
// One channel of the pulse measurement: a signed offset accumulator (PRE and
// POST samples) and a signed pulse accumulator (PULSE samples), both wrapping.
// On finish the result pulse_acc - offset_acc is registered (including a
// sample accepted in that same cycle) and both accumulators are cleared.
// Ports:
//   aclk, areset   clock, synchronous active-high reset
//   sample         signed channel sample
//   add_offset     accumulate sample into the offset sum this cycle
//   add_pulse      accumulate sample into the pulse sum this cycle
//   finish         close the measurement cycle, register the result
//   result_next    value the result register takes on finish
//   result         registered signed result
// -----------------------------------------------------------------------------
module axis_measure_pulse_acc
    import axis_measure_pulse_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    add_offset,
    input  logic                    add_pulse,
    input  logic                    finish,
    output logic [ACC_WIDTH-1:0]    result_next,
    output logic [ACC_WIDTH-1:0]    result
);

    logic [ACC_WIDTH-1:0] sample_ext;
    logic [ACC_WIDTH-1:0] offset_sum;
    logic [ACC_WIDTH-1:0] offset_acc_reg;
    logic [ACC_WIDTH-1:0] pulse_acc_reg;
    logic [ACC_WIDTH-1:0] result_reg;

    assign sample_ext  = ACC_WIDTH'($signed(sample));
    // The last POST sample arrives in the finish cycle, so it is folded in here.
    assign offset_sum  = offset_acc_reg + (add_offset ? sample_ext : '0);
    assign result_next = pulse_acc_reg - offset_sum;
    assign result      = result_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            offset_acc_reg <= '0;
            pulse_acc_reg  <= '0;
            result_reg     <= '0;
        end else if (finish) begin
            result_reg     <= result_next;
            offset_acc_reg <= '0;
            pulse_acc_reg  <= '0;
        end else begin
            offset_acc_reg <= offset_sum;
            if (add_pulse) begin
                pulse_acc_reg <= pulse_acc_reg + sample_ext;
            end
        end
    end

endmodule

// File: rtl/axis_measure_pulse_mc.sv
// -----------------------------------------------------------------------------
// axis_measure_pulse_mc
// Multi-channel pulse measurement with waveform playback from block RAM.
// A phase FSM (PRE, RAMP_UP, PULSE, RAMP_DOWN, POST) counts accepted samples;
// each channel computes pulse_sum - offset_sum per cycle and flags overload
// when the result is below threshold. A waveform segment
// [wfrm_start, wfrm_start+pulse_length] is streamed out of BRAM; an overload
// moves the segment forward until waveform_length is reached.
// Optional feature: define AXIS_MEASURE_PULSE_STICKY_EN to make overload bits
// sticky until a cycle with cfg clr=1.
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   cfg_data              {clr, pulse_length, waveform_length, threshold,
//                          width, ramp}
//   s_axis_*              packed per-channel signed samples (tready always 1)
//   m_axis_*              waveform playback stream
//   bram_porta_*          read port of the waveform BRAM (1-cycle latency)
//   overload              per-channel result < threshold
//   result_valid          one-cycle strobe, new results on sts_data
//   case_id               current phase
//   sts_data              per-channel 32-bit signed results
// -----------------------------------------------------------------------------
module axis_measure_pulse_mc
    import axis_measure_pulse_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int NUM_CH           = 2,
    parameter int CNTR_WIDTH       = 16,
    parameter int BRAM_ADDR_WIDTH  = 10,
    parameter int BRAM_DATA_WIDTH  = 16
) (
    input  logic                                      aclk,
    input  logic                                      areset,
    input  logic [2*CNTR_WIDTH+2*BRAM_ADDR_WIDTH+32:0] cfg_data,
    input  logic [NUM_CH*AXIS_TDATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    output logic [BRAM_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic                                      m_axis_tvalid,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,
    output logic                                      bram_porta_clk,
    output logic                                      bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]                bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]                bram_porta_rddata,
    output logic [NUM_CH-1:0]                         overload,
    output logic                                      result_valid,
    output logic [2:0]                                case_id,
    output logic [ACC_WIDTH*NUM_CH-1:0]               sts_data
);

    localparam int OFF_WIDTH = cfg_off_width(CNTR_WIDTH);
    localparam int OFF_THR   = cfg_off_thr(CNTR_WIDTH);
    localparam int OFF_WLEN  = cfg_off_wlen(CNTR_WIDTH);
    localparam int OFF_PLEN  = cfg_off_plen(CNTR_WIDTH, BRAM_ADDR_WIDTH);
    localparam int OFF_CLR   = cfg_off_clr(CNTR_WIDTH, BRAM_ADDR_WIDTH);

    // Live configuration fields
    logic [CNTR_WIDTH-1:0]      cfg_ramp;
    logic [CNTR_WIDTH-1:0]      cfg_width;
    logic [THR_WIDTH-1:0]       cfg_thr;
    logic [BRAM_ADDR_WIDTH-1:0] cfg_wlen;
    logic [BRAM_ADDR_WIDTH-1:0] cfg_plen;
    logic                       cfg_clr;

    assign cfg_ramp  = cfg_data[CFG_OFF_RAMP +: CNTR_WIDTH];
    assign cfg_width = cfg_data[OFF_WIDTH +: CNTR_WIDTH];
    assign cfg_thr   = cfg_data[OFF_THR +: THR_WIDTH];
    assign cfg_wlen  = cfg_data[OFF_WLEN +: BRAM_ADDR_WIDTH];
    assign cfg_plen  = cfg_data[OFF_PLEN +: BRAM_ADDR_WIDTH];
    assign cfg_clr   = cfg_data[OFF_CLR];

    // Configuration held constant for a whole measurement cycle
    logic [CNTR_WIDTH-1:0]      ramp_reg;
    logic [CNTR_WIDTH-1:0]      width_reg;
    logic [THR_WIDTH-1:0]       thr_reg;
    logic [BRAM_ADDR_WIDTH-1:0] wlen_reg;
    logic [BRAM_ADDR_WIDTH-1:0] plen_reg;

    phase_t                state_reg, state_next;
    logic [CNTR_WIDTH-1:0] cnt_reg, cnt_next;
    logic [CNTR_WIDTH-1:0] phase_len;
    logic                  phase_zero, sample_take, phase_done;
    logic                  add_offset, add_pulse, finish;

    logic [NUM_CH-1:0] ovl_new, ovl_upd, overload_reg;
    logic              result_valid_reg;

    logic [BRAM_ADDR_WIDTH-1:0] wfrm_start_reg;
    logic [BRAM_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [BRAM_ADDR_WIDTH-1:0] seg_end_reg;
    logic                       restart_reg, valid_reg, play_adv, seg_jump;

    // ---------------- phase FSM ----------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= PH_PRE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        case (state_reg)
            PH_RAMP_UP, PH_RAMP_DOWN: phase_len = ramp_reg;
            PH_PULSE:                 phase_len = width_reg;
            default:                  phase_len = width_reg >> 1;
        endcase
        // A zero-length phase lasts one cycle and ignores any sample in it.
        phase_zero  = (phase_len == '0);
        sample_take = s_axis_tvalid && !phase_zero;
        phase_done  = phase_zero ||
                      (sample_take && (cnt_reg == phase_len - CNTR_WIDTH'(1)));

        cnt_next = cnt_reg;
        if (phase_done) begin
            cnt_next = '0;
        end else if (sample_take) begin
            cnt_next = cnt_reg + CNTR_WIDTH'(1);
        end

        state_next = state_reg;
        if (phase_done) begin
            case (state_reg)
                PH_PRE:       state_next = PH_RAMP_UP;
                PH_RAMP_UP:   state_next = PH_PULSE;
                PH_PULSE:     state_next = PH_RAMP_DOWN;
                PH_RAMP_DOWN: state_next = PH_POST;
                default:      state_next = PH_PRE;
            endcase
        end

        add_offset = sample_take && (state_reg == PH_PRE || state_reg == PH_POST);
        add_pulse  = sample_take && (state_reg == PH_PULSE);
        finish     = phase_done && (state_reg == PH_POST);
    end

    // Latch configuration at reset and on entry to PRE
    always_ff @(posedge aclk) begin
        if (areset || finish) begin
            ramp_reg  <= cfg_ramp;
            width_reg <= cfg_width;
            thr_reg   <= cfg_thr;
            wlen_reg  <= cfg_wlen;
            plen_reg  <= cfg_plen;
        end
    end

    // ---------------- per-channel accumulators ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ACC_WIDTH-1:0] res_next;

            axis_measure_pulse_acc #(
                .SAMPLE_WIDTH(AXIS_TDATA_WIDTH)
            ) u_acc (
                .aclk       (aclk),
                .areset     (areset),
                .sample     (s_axis_tdata[gi*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH]),
                .add_offset (add_offset),
                .add_pulse  (add_pulse),
                .finish     (finish),
                .result_next(res_next),
                .result     (sts_data[gi*ACC_WIDTH +: ACC_WIDTH])
            );

            assign ovl_new[gi] = $signed(res_next) < $signed(thr_reg);
        end
    endgenerate

    // ---------------- overload flags ----------------
`ifdef AXIS_MEASURE_PULSE_STICKY_EN
    assign ovl_upd = overload_reg | ovl_new;
`else
    logic unused_cfg_clr;
    assign unused_cfg_clr = cfg_clr;
    assign ovl_upd = ovl_new;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            overload_reg <= '0;
`ifdef AXIS_MEASURE_PULSE_STICKY_EN
        end else if (cfg_clr) begin
            overload_reg <= '0;
`endif
        end else if (finish) begin
            overload_reg <= ovl_upd;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= finish;
        end
    end

    // ---------------- waveform playback ----------------
    assign play_adv = valid_reg && m_axis_tready;
    // Jump back to wfrm_start after the segment's last word, or at the next
    // word boundary once a new segment start has been chosen.
    assign seg_jump  = restart_reg || (addr_reg == seg_end_reg);
    assign addr_next = !play_adv ? addr_reg :
                       (seg_jump ? wfrm_start_reg : addr_reg + BRAM_ADDR_WIDTH'(1));

    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_reg    <= '0;
            valid_reg   <= 1'b0;
            seg_end_reg <= cfg_plen;
        end else begin
            addr_reg  <= addr_next;
            valid_reg <= 1'b1;
            if (play_adv && seg_jump) begin
                seg_end_reg <= wfrm_start_reg + plen_reg;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wfrm_start_reg <= '0;
            restart_reg    <= 1'b0;
        end else if (finish) begin
            restart_reg <= 1'b1;
            if ((|ovl_upd) && (wfrm_start_reg < wlen_reg)) begin
                wfrm_start_reg <= wfrm_start_reg + plen_reg + BRAM_ADDR_WIDTH'(1);
            end else begin
                wfrm_start_reg <= '0;
            end
        end else if (play_adv) begin
            restart_reg <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign s_axis_tready   = 1'b1;
    assign m_axis_tdata    = bram_porta_rddata;
    assign m_axis_tvalid   = valid_reg;
    assign m_axis_tlast    = valid_reg && (addr_reg == seg_end_reg);
    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = areset;
    assign bram_porta_addr = areset ? '0 : addr_next;
    assign overload        = overload_reg;
    assign result_valid    = result_valid_reg;
    assign case_id         = state_reg;

endmodule

// File: tb/tb_axis_measure_pulse_mc.sv
// -----------------------------------------------------------------------------
// tb_axis_measure_pulse_mc
// Directed bench for axis_measure_pulse_mc (default parameters, NUM_CH=2).
// A behavioural BRAM returns word(a) = a*5+3 one cycle after the address.
// -----------------------------------------------------------------------------
module tb_axis_measure_pulse_mc;

    localparam int CFGW = 85;

    logic             aclk;
    logic             areset;
    logic [CFGW-1:0]  cfg_data;
    logic [31:0]      s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [15:0]      m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready;
    logic             bram_porta_clk;
    logic             bram_porta_rst;
    logic [9:0]       bram_porta_addr;
    logic [15:0]      bram_porta_rddata;
    logic [1:0]       overload;
    logic             result_valid;
    logic [2:0]       case_id;
    logic [63:0]      sts_data;

    int n_checks = 0;
    int n_errors = 0;

`ifdef AXIS_MEASURE_PULSE_STICKY_EN
    localparam logic [1:0] OVL_CYCLE3 = 2'b01;
`else
    localparam logic [1:0] OVL_CYCLE3 = 2'b00;
`endif

    axis_measure_pulse_mc dut (
        .aclk             (aclk),
        .areset           (areset),
        .cfg_data         (cfg_data),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready),
        .bram_porta_clk   (bram_porta_clk),
        .bram_porta_rst   (bram_porta_rst),
        .bram_porta_addr  (bram_porta_addr),
        .bram_porta_rddata(bram_porta_rddata),
        .overload         (overload),
        .result_valid     (result_valid),
        .case_id          (case_id),
        .sts_data         (sts_data)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [15:0] bram_word(input logic [9:0] a);
        return 16'(a) * 16'd5 + 16'd3;
    endfunction

    always @(posedge aclk) begin
        bram_porta_rddata <= bram_word(bram_porta_addr);
    end

    function automatic logic [CFGW-1:0] make_cfg(input logic clr, input int plen, input int wlen,
                                                input int thr, input int width, input int ramp);
        return {clr, 10'(plen), 10'(wlen), 32'(thr), 16'(width), 16'(ramp)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one full measurement cycle; ch0 PRE/POST=10, PULSE=p0;
    // ch1 PRE/POST=-20, PULSE=30; ramp samples carry junk that must be ignored.
    task automatic run_cycle(input int rmp, input int p0, input int exp0, input int exp1,
                             input logic [1:0] exp_ovl);
        int cnt [5];
        int v0;
        int v1;
        int nr;
        nr  = (rmp == 0) ? 1 : rmp;
        cnt = '{2, nr, 4, nr, 2};
        for (int ph = 0; ph < 5; ph++) begin
            for (int k = 0; k < cnt[ph]; k++) begin
                @(negedge aclk);
                if (ph == 0 || ph == 4) begin
                    v0 = 10;
                    v1 = -20;
                end else if (ph == 2) begin
                    v0 = p0;
                    v1 = 30;
                end else begin
                    v0 = 999;
                    v1 = -7;
                end
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {16'(v1), 16'(v0)};
                #1;
                check("case_id", 64'(case_id), 64'(ph));
                check("rv_early", 64'(result_valid), 64'd0);
            end
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        #1;
        check("result_valid", 64'(result_valid), 64'd1);
        check("result_ch0", 64'(sts_data[31:0]), 64'(32'(exp0)));
        check("result_ch1", 64'(sts_data[63:32]), 64'(32'(exp1)));
        check("overload", 64'(overload), 64'(exp_ovl));
        check("case_after", 64'(case_id), 64'd0);
        $display("cycle ramp=%0d: result0=%0d result1=%0d overload=%b",
                 rmp, $signed(sts_data[31:0]), $signed(sts_data[63:32]), overload);
        @(negedge aclk);
        #1;
        check("rv_strobe", 64'(result_valid), 64'd0);
    endtask

    // One beat with tready=1; checks the word that appears next.
    task automatic step_play(input int exp_addr, input logic exp_last);
        @(negedge aclk);
        m_axis_tready = 1'b1;
        @(negedge aclk);
        m_axis_tready = 1'b0;
        #1;
        check("play_data", 64'(m_axis_tdata), 64'(bram_word(10'(exp_addr))));
        check("play_last", 64'(m_axis_tlast), 64'(exp_last));
        $display("beat addr=%0d data=%0d last=%0b", exp_addr, m_axis_tdata, m_axis_tlast);
    endtask

    initial begin
        int exp_addr;
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        cfg_data      = make_cfg(1'b0, 7, 8, 200, 4, 2);

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        check("rst_overload", 64'(overload), 64'd0);
        check("rst_rv", 64'(result_valid), 64'd0);
        check("rst_sts", sts_data, 64'd0);
        check("rst_case", 64'(case_id), 64'd0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_addr", 64'(bram_porta_addr), 64'd0);
        check("tready", 64'(s_axis_tready), 64'd1);

        @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        check("tvalid_up", 64'(m_axis_tvalid), 64'd1);

        // Playback with tready toggling every cycle: 0..7,0,1 unbroken
        exp_addr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            m_axis_tready = (i % 2 == 1);
            #1;
            check("pb_data", 64'(m_axis_tdata), 64'(bram_word(10'(exp_addr))));
            check("pb_last", 64'(m_axis_tlast), 64'(exp_addr == 7));
            if (m_axis_tready) begin
                $display("beat addr=%0d data=%0d last=%0b", exp_addr, m_axis_tdata, m_axis_tlast);
                exp_addr = (exp_addr == 7) ? 0 : exp_addr + 1;
            end
        end
        @(negedge aclk);
        m_axis_tready = 1'b0;

        // Cycle 1: 160 / 200, threshold 200 -> only ch0 overloads
        run_cycle(2, 50, 160, 200, 2'b01);
        check("hold_data", 64'(m_axis_tdata), 64'(bram_word(10'(exp_addr))));
        // wfrm_start 0 -> 8
        step_play(8, 1'b0);

        // New cfg is only latched at the end of the next cycle
        cfg_data = make_cfg(1'b0, 7, 8, 100, 4, 0);
        run_cycle(2, 50, 160, 200, 2'b01);
        // wfrm_start 8 is not below waveform_length 8 -> back to 0
        step_play(0, 1'b0);

        // Cycle 3: ramp=0, threshold 100 -> no new overload
        run_cycle(0, 50, 160, 200, OVL_CYCLE3);

        // clr pulse
        @(negedge aclk);
        cfg_data = make_cfg(1'b1, 7, 8, 100, 4, 0);
        @(negedge aclk);
        cfg_data = make_cfg(1'b0, 7, 8, 100, 4, 0);
        #1;
        check("ovl_after_clr", 64'(overload), 64'd0);

        // Reset in the middle of a measurement cycle
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {16'd77, 16'd55};
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        areset        = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        check("mid_rst_rv", 64'(result_valid), 64'd0);
        check("mid_rst_sts", sts_data, 64'd0);
        check("mid_rst_case", 64'(case_id), 64'd0);
        areset = 1'b0;
        // Partial sums discarded: 240 - 40 = 200, 120 + 80 = 200
        run_cycle(0, 60, 200, 200, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
